// File: rtl/cpu_pkg.sv
// Shared definitions for the 10-bit pipelined CPU: datapath widths, opcode
// field location, reserved encodings and the fetch state machine encoding.
package cpu_pkg;

  localparam int CPU_ADDR_W  = 10;
  localparam int CPU_INSTR_W = 10;

  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 7;

  localparam logic [OPC_MSB-OPC_LSB:0] CPU_HALT_OPCODE = 3'b111;
  localparam logic [CPU_INSTR_W-1:0]   CPU_NOP_WORD    = 10'b0000000000;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HALTED = 2'd1;
  localparam logic [1:0] ST_FAULT  = 2'd2;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [CPU_INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched word and its PC, or holds, or
// collapses to a bubble. Flush beats hold, hold beats load.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = CPU_ADDR_W,
  parameter int                 INSTR_W  = CPU_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = CPU_NOP_WORD
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               flush,
  input  logic               hold,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid
);

  // Anything that is neither held nor loaded turns into a bubble.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      if_id_instruction <= NOP_WORD;
      if_id_pc          <= '0;
      if_id_valid       <= 1'b0;
    end else if (hold) begin
      if_id_instruction <= if_id_instruction;
      if_id_pc          <= if_id_pc;
      if_id_valid       <= if_id_valid;
    end else if (load) begin
      if_id_instruction <= instruction;
      if_id_pc          <= pc;
      if_id_valid       <= 1'b1;
    end else begin
      if_id_instruction <= NOP_WORD;
      if_id_pc          <= '0;
      if_id_valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and RUN/HALTED/FAULT state, drives the
// instruction memory address and fills the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                        ADDR_W      = CPU_ADDR_W,
  parameter int                        INSTR_W     = CPU_INSTR_W,
  parameter int                        MEM_DEPTH   = 33,
  parameter logic [ADDR_W-1:0]         RESET_PC    = '0,
  parameter logic [OPC_MSB-OPC_LSB:0]  HALT_OPCODE = CPU_HALT_OPCODE,
  parameter logic [INSTR_W-1:0]        NOP_WORD    = CPU_NOP_WORD
) (
  input  logic               clock,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] if_id_instruction,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic               fetch_fault
);

  // One extra bit so depths up to 2^ADDR_W compare correctly.
  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W+1)'(MEM_DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
  logic              in_range;
  logic              halt_word;
  logic              fetch_ok;

  assign imem_address = pc;
  assign in_range     = {1'b0, pc} < DEPTH_LIMIT;
  assign halt_word    = opcode_of(imem_instruction) == HALT_OPCODE;
  assign fetch_ok     = (state == ST_RUN) && in_range;
  assign halted       = state == ST_HALTED;
  assign fetch_fault  = state == ST_FAULT;

  // A redirect always wins over stall and restarts fetch, even from HALTED/FAULT.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      state <= ST_RUN;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (!in_range) begin
            state <= ST_FAULT;
          end else if (halt_word) begin
            state <= ST_HALTED;
          end else begin
            pc <= pc + ADDR_W'(1);
          end
        end
        ST_HALTED, ST_FAULT: begin
          state <= state;
        end
        default: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clock             (clock),
    .reset             (reset),
    .load              (fetch_ok),
    .flush             (redirect_valid),
    .hold              (stall),
    .instruction       (imem_instruction),
    .pc                (pc),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_valid       (if_id_valid)
  );

endmodule
